// File: rtl/clk_gate_ctrl_pkg.sv
// Shared state encoding and parameter-range helper for the clock-gate controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int unsigned MAX_NREQ = 16;

  // True when v is a loadable, non-zero cycle count for a w-bit timer.
  function automatic bit cnt_fits(input int unsigned v, input int unsigned w);
    return (v >= 1) && (longint'(v) < (longint'(1) << w));
  endfunction

endpackage

// File: rtl/clk_ctrl_timer.sv
// Saturating down-counter shared by the wake-delay and hold-window phases.
module clk_ctrl_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller: req/ack handshake, wake delay before grant, hold window before gate-off.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 4,
  parameter int HOLD_CYC = 8,
  parameter int CNT_W    = 8
) (
  input  logic            mclk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic            clk_en,
  output logic            busy,
  output logic [1:0]      state_o
);

  if (NREQ < 1 || NREQ > int'(MAX_NREQ)) begin : g_bad_nreq
    $error("clk_gate_ctrl: NREQ out of range 1..16");
  end
  if (!cnt_fits(WAKE_CYC, CNT_W)) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYC does not fit the timer");
  end
  if (!cnt_fits(HOLD_CYC, CNT_W)) begin : g_bad_hold
    $error("clk_gate_ctrl: HOLD_CYC does not fit the timer");
  end

  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              clk_en_q, clk_en_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;

  clk_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (mclk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    clk_en_d = clk_en_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        ack_d    = '0;
        clk_en_d = 1'b0;
        if (|req) begin
          state_d  = ST_WAKE;
          clk_en_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = WAKE_LD;
        end
      end
      // WAKE never aborts: the buffer needs the full delay to settle.
      ST_WAKE: begin
        ack_d = '0;
        if (tmr_zero) begin
          state_d = ST_ON;
          ack_d   = req;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ON: begin
        ack_d = req;
        if (req == '0) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      // A new request beats timer expiry, so the clock never blips off.
      ST_HOLD: begin
        ack_d = '0;
        if (|req) begin
          state_d = ST_ON;
          ack_d   = req;
        end else if (tmr_zero) begin
          state_d  = ST_OFF;
          clk_en_d = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      ack_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign ack     = ack_q;
  assign clk_en  = clk_en_q;
  assign busy    = (state_q != ST_OFF);
  assign state_o = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: abstract cycle model checked every cycle plus literal checkpoints.
module tb_clk_gate_ctrl;

  localparam int NREQ     = 4;
  localparam int WAKE_CYC = 4;
  localparam int HOLD_CYC = 8;
  localparam int CNT_W    = 8;

  logic            mclk = 1'b0;
  logic            rst  = 1'b1;
  logic [NREQ-1:0] req  = '0;
  logic [NREQ-1:0] ack;
  logic            clk_en;
  logic            busy;
  logic [1:0]      state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  clk_gate_ctrl #(
    .NREQ(NREQ), .WAKE_CYC(WAKE_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)
  ) dut (
    .mclk    (mclk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .clk_en  (clk_en),
    .busy    (busy),
    .state_o (state_o)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: the clock is either gated, settling (wake_rem edges left), or
  // stable; when stable, ack mirrors req and idle counts request-free edges.
  bit              m_en      = 1'b0;
  int              m_wake    = 0;
  int              m_idle    = 0;
  logic [NREQ-1:0] m_ack     = '0;

  function automatic logic [1:0] m_state();
    if (!m_en)           return 2'd0;
    else if (m_wake > 0) return 2'd1;
    else if (m_idle == 0) return 2'd2;
    else                 return 2'd3;
  endfunction

  always @(posedge mclk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_en = 1'b0; m_wake = 0; m_idle = 0; m_ack = '0;
    end else if (!m_en) begin
      m_ack = '0;
      if (|req) begin
        m_en = 1'b1; m_wake = WAKE_CYC; m_idle = 0;
      end
    end else if (m_wake > 0) begin
      m_wake--;
      m_ack  = (m_wake == 0) ? req : '0;
      m_idle = 0;
    end else if (|req) begin
      m_ack  = req;
      m_idle = 0;
    end else begin
      m_ack = '0;
      m_idle++;
      if (m_idle > HOLD_CYC) begin
        m_en = 1'b0; m_idle = 0;
      end
    end
  end

  always @(negedge mclk) begin
    if (cyc >= 1) begin
      check("model_state",  32'(state_o), 32'(m_state()));
      check("model_clk_en", 32'(clk_en),  32'(m_en));
      check("model_ack",    32'(ack),     32'(m_ack));
      check("model_busy",   32'(busy),    32'(m_en));
      check("ack_safe", 32'((|ack) && (!clk_en || state_o == 2'd1)), 32'd0);
    end
  end

  // Returns at the falling edge following rising edge k.
  task automatic after_edge(input int k);
    do @(negedge mclk); while (cyc < k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    after_edge(2);
    check("reset_state",  32'(state_o), 32'd0);
    check("reset_clk_en", 32'(clk_en),  32'd0);
    check("reset_ack",    32'(ack),     32'd0);
    check("reset_busy",   32'(busy),    32'd0);
    rst = 1'b0;

    // Single wake, release, gate-off.
    after_edge(9);  req = 4'b0001;
    after_edge(10); check("wake_clk_en", 32'(clk_en), 32'd1);
                    check("wake_state",  32'(state_o), 32'd1);
    after_edge(13); check("wake_no_ack_early", 32'(ack), 32'd0);
    after_edge(14); check("wake_ack", 32'(ack), 32'h1);
                    check("wake_on",  32'(state_o), 32'd2);
    after_edge(19); req = '0;
    after_edge(20); check("rel_ack", 32'(ack), 32'd0);
                    check("rel_hold", 32'(state_o), 32'd3);
    after_edge(27); check("hold_still_en", 32'(clk_en), 32'd1);
    after_edge(28); check("gate_off", 32'(clk_en), 32'd0);
                    check("gate_off_state", 32'(state_o), 32'd0);

    // Re-request in HOLD, simultaneous rises, request on expiry edge.
    after_edge(39); req = 4'b0001;
    after_edge(44); check("wake2_ack", 32'(ack), 32'h1);
    after_edge(49); req = '0;
    after_edge(53); req = 4'b0100;
    after_edge(54); check("rereq_ack", 32'(ack), 32'h4);
                    check("rereq_state", 32'(state_o), 32'd2);
                    check("rereq_clk_en", 32'(clk_en), 32'd1);
    after_edge(59); req = 4'b1101;
    after_edge(60); check("multi_ack", 32'(ack), 32'hd);
    after_edge(69); req = '0;
    after_edge(77); check("pre_expiry_hold", 32'(state_o), 32'd3);
                    req = 4'b0010;
    after_edge(78); check("expiry_on",  32'(state_o), 32'd2);
                    check("expiry_ack", 32'(ack), 32'h2);
                    check("expiry_en",  32'(clk_en), 32'd1);
    after_edge(84); req = '0;
    after_edge(93); check("gate_off2", 32'(clk_en), 32'd0);

    // Aborted request: two-cycle pulse in OFF.
    after_edge(99);  req = 4'b0001;
    after_edge(101); req = '0;
    after_edge(104); check("abort_on",   32'(state_o), 32'd2);
                     check("abort_ack",  32'(ack), 32'd0);
    after_edge(105); check("abort_hold", 32'(state_o), 32'd3);
    after_edge(112); check("abort_en", 32'(clk_en), 32'd1);
    after_edge(113); check("abort_off", 32'(clk_en), 32'd0);

    // Reset mid-WAKE and mid-HOLD.
    after_edge(119); req = 4'b0001;
    after_edge(121); rst = 1'b1;
    after_edge(122); check("rst_wake_state", 32'(state_o), 32'd0);
                     check("rst_wake_en",    32'(clk_en), 32'd0);
                     check("rst_wake_busy",  32'(busy), 32'd0);
                     rst = 1'b0;
    after_edge(127); check("rewake_ack", 32'(ack), 32'h1);
    after_edge(129); req = '0;
    after_edge(132); rst = 1'b1;
    after_edge(133); check("rst_hold_state", 32'(state_o), 32'd0);
                     check("rst_hold_en",    32'(clk_en), 32'd0);
                     check("rst_hold_ack",   32'(ack), 32'd0);
                     rst = 1'b0;
    after_edge(140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
